// File: rtl/fir_to_posit_pipe.sv
// Long-FIR to N-bit posit converter: two-stage valid/ready pipeline
// (decompose, then pack + round-to-nearest-even + sign). Optional macro FIR2P_SAT_CNT_EN adds sat_count_o.
package fir_to_posit_pkg;
    localparam int TE_BITS        = 8;
    localparam int FRAC_FULL_SIZE = 32;

    typedef struct packed {
        logic [TE_BITS+FRAC_FULL_SIZE:0] long_fir;  // {sign, te, frac}
        logic                            frac_truncated;
    } ops_out_meta_t;
endpackage

module fir_to_posit_pipe #(
    parameter int N              = 16,
    parameter int ES             = 1,
    parameter int TE_BITS        = fir_to_posit_pkg::TE_BITS,
    parameter int FRAC_FULL_SIZE = fir_to_posit_pkg::FRAC_FULL_SIZE
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  fir_to_posit_pkg::ops_out_meta_t ops_result_i,
    input  logic                            in_is_zero_i,
    input  logic                            in_is_nar_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [N-1:0]                    posit_o
`ifdef FIR2P_SAT_CNT_EN
    ,
    output logic [15:0]                     sat_count_o
`endif
);
    localparam int FW  = FRAC_FULL_SIZE;
    localparam int PAD = N - 3;               // largest regime shift that is not saturated
    localparam int X   = ES + FW + N - 2;     // regime seed (2) + e + frac w/o hidden + PAD
    localparam logic signed [TE_BITS-1:0] K_MAX = TE_BITS'(N - 2);
    localparam logic signed [TE_BITS-1:0] K_MIN = TE_BITS'(-(N - 2));
    localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] NAR    = {1'b1, {(N-1){1'b0}}};

    logic [2:1] vld_pipe;
    logic       s1_load, s2_load;

    assign s2_load     = !vld_pipe[2] || out_ready_i;
    assign s1_load     = !vld_pipe[1] || s2_load;
    assign in_ready_o  = s1_load;
    assign out_valid_o = vld_pipe[2];

    // stage 1: decompose te into regime k and exponent e
    logic                      in_sign;
    logic signed [TE_BITS-1:0] in_te, in_k;
    logic                      unused_hidden;

    assign in_sign       = ops_result_i.long_fir[TE_BITS+FW];
    assign in_te         = ops_result_i.long_fir[TE_BITS+FW-1:FW];
    assign in_k          = in_te >>> ES;
    assign unused_hidden = ops_result_i.long_fir[FW-1];

    logic                      s1_sign, s1_sticky, s1_nar, s1_zero, s1_sat_hi, s1_sat_lo;
    logic signed [TE_BITS-1:0] s1_k;
    logic [ES-1:0]             s1_e;
    logic [FW-2:0]             s1_frac;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe[1] <= 1'b0;
            s1_sign     <= 1'b0;
            s1_sticky   <= 1'b0;
            s1_nar      <= 1'b0;
            s1_zero     <= 1'b0;
            s1_sat_hi   <= 1'b0;
            s1_sat_lo   <= 1'b0;
            s1_k        <= '0;
            s1_e        <= '0;
            s1_frac     <= '0;
        end else if (s1_load) begin
            vld_pipe[1] <= in_valid_i;
            if (in_valid_i) begin
                s1_sign   <= in_sign;
                s1_sticky <= ops_result_i.frac_truncated;
                s1_nar    <= in_is_nar_i;
                s1_zero   <= in_is_zero_i;
                s1_sat_hi <= in_k >= K_MAX;
                s1_sat_lo <= in_k < K_MIN;
                s1_k      <= in_k;
                s1_e      <= in_te[ES-1:0];
                s1_frac   <= ops_result_i.long_fir[FW-2:0];
            end
        end
    end

    // stage 2: seed "10" (k>=0) or "01" (k<0) and shift so the regime run
    // length falls out of the fill bit; -k-1 == ~k for the negative case.
    logic                neg_k;
    logic [TE_BITS-1:0]  shamt;
    logic [X-1:0]        base, sh_lr, shifted;
    logic signed [X-1:0] sh_ar;
    logic [N:0]          work;
    logic [N-2:0]        mag_w;
    logic                grd, rnd, stk, inc;
    logic [N-1:0]        sum, mag, signed_mag, posit_nxt;

    assign neg_k   = s1_k[TE_BITS-1];
    assign shamt   = neg_k ? ~s1_k : s1_k;
    assign base    = {~neg_k, neg_k, s1_e, s1_frac, {PAD{1'b0}}};
    assign sh_ar   = $signed(base) >>> shamt;
    assign sh_lr   = base >> shamt;
    assign shifted = neg_k ? sh_lr : sh_ar;
    assign work    = shifted[X-1 -: N+1];
    assign mag_w   = work[N:2];
    assign grd     = work[1];
    assign rnd     = work[0];
    assign stk     = (|shifted[X-N-2:0]) || s1_sticky;
    assign inc     = grd && (mag_w[0] || rnd || stk);
    assign sum     = {1'b0, mag_w} + {{(N-1){1'b0}}, inc};

    always_comb begin
        mag = sum[N-1] ? MAXPOS : sum;
        if (s1_sat_hi) mag = MAXPOS;
        if (s1_sat_lo) mag = {{(N-1){1'b0}}, 1'b1};
        signed_mag = s1_sign ? (~mag + N'(1)) : mag;
        posit_nxt  = signed_mag;
        if (s1_zero) posit_nxt = '0;
        if (s1_nar)  posit_nxt = NAR;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe[2] <= 1'b0;
            posit_o     <= '0;
        end else if (s2_load) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) posit_o <= posit_nxt;
        end
    end

`ifdef FIR2P_SAT_CNT_EN
    logic s2_sat;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_sat      <= 1'b0;
            sat_count_o <= '0;
        end else begin
            if (s2_load && vld_pipe[1]) s2_sat <= s1_sat_hi || s1_sat_lo;
            if (vld_pipe[2] && out_ready_i && s2_sat && sat_count_o != 16'hFFFF)
                sat_count_o <= sat_count_o + 16'd1;
        end
    end
`endif
endmodule
